store_result_monitor: RTL and testbench
=======================================

Name: store_result_monitor

Overview:
- Synthesizable pass/fail checker downstream of the CPU top's data-memory store port (memwrite, dataadr, writedata).
- Watches every store and compares it against three programmed "test complete" signatures: standard2, power2 and loadstore.
- Runs a cycle watchdog and latches a sticky verdict. Usable on FPGA (LEDs) or as a bench-side checker replacing ad-hoc simulation watches.

Parameters:
- TIMEOUT, 512, cycles in RUN without a signature match before FAIL.
- CNT_W, 10, width of cycle counter; must satisfy 2^CNT_W >= TIMEOUT.
- ADDR_STD, 84, store address signalling standard2 pass.
- DATA_STD, 7, store data signalling standard2 pass.
- ADDR_PWR, 128, store address signalling power2 pass.
- DATA_PWR, 7, store data signalling power2 pass.
- ADDR_LS, 80, store address signalling loadstore pass.
- DATA_LS, 1, store data signalling loadstore pass.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- memwrite, input, 2, store strobe from CPU; any nonzero value = store this cycle.
- dataadr, input, 64, store byte address.
- writedata, input, 64, store data.
- pass, output, 1, sticky: a signature matched.
- fail, output, 1, sticky: watchdog expired first.
- done, output, 1, pass | fail.
- pass_id, output, 2, 0 = none, 1 = standard2, 2 = power2, 3 = loadstore.
- cycle_cnt, output, CNT_W, cycles elapsed in RUN.
- store_cnt, output, 8, number of stores seen, saturating.

Behaviour:
- Reset (async, active-high) puts the FSM in RUN and clears pass, fail, done, pass_id, cycle_cnt and store_cnt to 0. Reset asserted mid-run or after a verdict clears everything immediately, without waiting for a clock. Release is synchronous to the next rising edge.
- FSM states: RUN, PASS, FAIL. PASS and FAIL are terminal until reset.
- A store is valid when memwrite != 2'b00. Comparison uses the full 64-bit dataadr and writedata with exact equality.
- Match priority within one cycle: standard2 > power2 > loadstore. With default parameters ADDR_PWR and ADDR_LS are distinct, so multi-match only occurs with custom parameters.
- In RUN, each rising edge:
  - Valid store matching a signature -> next state PASS; pass = 1, pass_id set; visible one cycle after the store cycle (registered, latency 1).
  - Otherwise, if cycle_cnt == TIMEOUT-1 -> next state FAIL; fail = 1. fail therefore rises after exactly TIMEOUT RUN cycles.
  - Otherwise cycle_cnt increments.
- A match in the same cycle as cycle_cnt == TIMEOUT-1 resolves to PASS (pass wins).
- store_cnt increments on each valid store in RUN, including the matching one. It saturates at 255 (no wrap) and freezes in PASS/FAIL.
- cycle_cnt freezes in PASS/FAIL and holds its final value.
- pass and fail are never both 1. done = pass | fail, registered, same timing as pass/fail.
- Stores after a verdict are ignored. A non-matching store to a signature address (e.g. addr 84, data 6) does not match and does not fail.

Optional Feature:
- Macro STORE_LOG_EN.
- When defined: adds outputs last_adr[63:0], last_data[63:0] and last_we[1:0], capturing dataadr/writedata/memwrite of the most recent valid store while in RUN. All reset to 0 and freeze at verdict, so on FAIL they show the final store before timeout.
- When undefined: these ports and registers do not exist. Core behaviour is identical.

Test Plan:
- Reset held 22 ns, then a store memwrite=2'b01, adr=84, data=7 at cycle 5 -> next cycle pass=1, pass_id=1, done=1, store_cnt=1, cycle_cnt=5.
- Store adr=128, data=7 -> pass_id=2. Separate run: store adr=80, data=1 -> pass_id=3. A later store adr=84, data=7 leaves pass_id unchanged.
- No matching stores; 300 stores adr=84, data=6 -> fail=1 exactly 512 cycles after reset release, pass=0, store_cnt=255 (saturated), cycle_cnt=511.
- Matching store adr=80, data=1 presented on the cycle where cycle_cnt=511 -> pass=1, pass_id=3, fail=0.
- After PASS, assert reset asynchronously between clock edges -> all outputs 0 immediately. Release -> counting restarts from 0.
- With STORE_LOG_EN: stores (adr=16, data=3, we=2'b10) then (adr=24, data=9, we=2'b01), then timeout -> fail=1, last_adr=24, last_data=9, last_we=2'b01.

Source files
------------

// File: rtl/store_result_monitor_if.sv
// ---------------------------------------------------------------------------
// store_result_monitor_if
//
// Purpose : Bundles the CPU data-memory store port so that the pass/fail
//           checker can be attached with a single connection.
//
// Signals : memwrite  [1:0]  store strobe, any nonzero value means a store
//           dataadr   [63:0] store byte address
//           writedata [63:0] store data
//
// Modports: master - the CPU side that drives the store port
//           slave  - the checker side that only observes it
// ---------------------------------------------------------------------------
interface store_result_monitor_if;

    logic [1:0]  memwrite;
    logic [63:0] dataadr;
    logic [63:0] writedata;

    modport master (
        output memwrite,
        output dataadr,
        output writedata
    );

    modport slave (
        input memwrite,
        input dataadr,
        input writedata
    );

endinterface

// File: rtl/store_result_monitor.sv
// ---------------------------------------------------------------------------
// store_result_monitor
//
// Purpose : Pass/fail checker that sits on the CPU data-memory store port.
//           Every store is compared against three "test complete"
//           signatures (standard2, power2, loadstore). A cycle watchdog
//           declares failure if no signature arrives within TIMEOUT cycles.
//           The verdict is sticky until reset.
//
// Ports   : clk        system clock, all state changes on the rising edge
//           reset      asynchronous active-high reset
//           store      store port (memwrite, dataadr, writedata), slave side
//           pass       sticky, a signature matched
//           fail       sticky, watchdog expired before any match
//           done       pass | fail
//           pass_id    0 none, 1 standard2, 2 power2, 3 loadstore
//           cycle_cnt  cycles spent in RUN, frozen at the verdict
//           store_cnt  stores seen in RUN, saturating at 255
//
// Optional: define STORE_LOG_EN to add last_adr, last_data and last_we,
//           which hold the most recent store seen while running.
// ---------------------------------------------------------------------------
module store_result_monitor #(
    parameter int          TIMEOUT  = 512,
    parameter int          CNT_W    = 10,
    parameter logic [63:0] ADDR_STD = 64'd84,
    parameter logic [63:0] DATA_STD = 64'd7,
    parameter logic [63:0] ADDR_PWR = 64'd128,
    parameter logic [63:0] DATA_PWR = 64'd7,
    parameter logic [63:0] ADDR_LS  = 64'd80,
    parameter logic [63:0] DATA_LS  = 64'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    store_result_monitor_if.slave  store,
    output logic                   pass,
    output logic                   fail,
    output logic                   done,
    output logic [1:0]             pass_id,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [7:0]             store_cnt
`ifdef STORE_LOG_EN
    ,
    output logic [63:0]            last_adr,
    output logic [63:0]            last_data,
    output logic [1:0]             last_we
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    // The watchdog fires on the edge where the counter already shows its
    // last allowed value, so fail rises after exactly TIMEOUT RUN cycles.
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       passId_q;
    logic [1:0]       passId_d;
    logic [CNT_W-1:0] cycleCnt_q;
    logic [CNT_W-1:0] cycleCnt_d;
    logic [7:0]       storeCnt_q;
    logic [7:0]       storeCnt_d;

    logic storeValid;
    logic matchStd;
    logic matchPwr;
    logic matchLs;
    logic anyMatch;

    // A store is any nonzero strobe; signatures need exact 64-bit equality
    // on both address and data.
    assign storeValid = |store.memwrite;
    assign matchStd   = storeValid && (store.dataadr == ADDR_STD) && (store.writedata == DATA_STD);
    assign matchPwr   = storeValid && (store.dataadr == ADDR_PWR) && (store.writedata == DATA_PWR);
    assign matchLs    = storeValid && (store.dataadr == ADDR_LS)  && (store.writedata == DATA_LS);
    assign anyMatch   = matchStd || matchPwr || matchLs;

    // State and counter registers; reset returns to RUN with everything
    // cleared without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            passId_q   <= 2'd0;
            cycleCnt_q <= '0;
            storeCnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            passId_q   <= passId_d;
            cycleCnt_q <= cycleCnt_d;
            storeCnt_q <= storeCnt_d;
        end
    end

    // Next-state logic. A signature match beats the watchdog in the same
    // cycle, and standard2 > power2 > loadstore when several match at once.
    // PASS and FAIL hold every register, which freezes the counters.
    always_comb begin
        state_d    = state_q;
        passId_d   = passId_q;
        cycleCnt_d = cycleCnt_q;
        storeCnt_d = storeCnt_q;
        case (state_q)
            RUN: begin
                if (storeValid && (storeCnt_q != 8'hFF)) begin
                    storeCnt_d = storeCnt_q + 8'd1;
                end
                if (anyMatch) begin
                    state_d = PASS;
                    if (matchStd) begin
                        passId_d = 2'd1;
                    end else if (matchPwr) begin
                        passId_d = 2'd2;
                    end else begin
                        passId_d = 2'd3;
                    end
                end else if (cycleCnt_q == LAST_CYCLE) begin
                    state_d = FAIL;
                end else begin
                    cycleCnt_d = cycleCnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Verdict flags come straight from the state register, so they are
    // registered, mutually exclusive and share the same one-cycle latency.
    assign pass      = (state_q == PASS);
    assign fail      = (state_q == FAIL);
    assign done      = pass | fail;
    assign pass_id   = passId_q;
    assign cycle_cnt = cycleCnt_q;
    assign store_cnt = storeCnt_q;

`ifdef STORE_LOG_EN
    logic [63:0] lastAdr_q;
    logic [63:0] lastData_q;
    logic [1:0]  lastWe_q;

    // Capture only while running so that after a timeout the log shows the
    // final store made before the verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastAdr_q  <= 64'd0;
            lastData_q <= 64'd0;
            lastWe_q   <= 2'd0;
        end else if ((state_q == RUN) && storeValid) begin
            lastAdr_q  <= store.dataadr;
            lastData_q <= store.writedata;
            lastWe_q   <= store.memwrite;
        end
    end

    assign last_adr  = lastAdr_q;
    assign last_data = lastData_q;
    assign last_we   = lastWe_q;
`endif

endmodule

// File: tb/tb_store_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_store_result_monitor
//
// Purpose : Self-checking bench for store_result_monitor. Each run loads a
//           cycle-by-cycle store script, derives the expected verdict from
//           the script (first signature store inside the watchdog window),
//           queues it, and a separate monitor compares it when done rises.
//
// Optional: define STORE_LOG_EN to also exercise the store log outputs.
// ---------------------------------------------------------------------------
module tb_store_result_monitor;

    localparam int TIMEOUT = 512;
    localparam int CNT_W   = 10;
    localparam int RUN_LEN = TIMEOUT + 8;

    typedef struct {
        logic        expPass;
        logic        expFail;
        logic [1:0]  expId;
        int          expCycle;
        int          expStores;
        int          expEdge;
        logic [63:0] expAdr;
        logic [63:0] expData;
        logic [1:0]  expWe;
    } expect_t;

    logic             clk;
    logic             reset;
    logic             pass;
    logic             fail;
    logic             done;
    logic [1:0]       passId;
    logic [CNT_W-1:0] cycleCnt;
    logic [7:0]       storeCnt;
`ifdef STORE_LOG_EN
    logic [63:0]      lastAdr;
    logic [63:0]      lastData;
    logic [1:0]       lastWe;
`endif

    int checks = 0;
    int passes = 0;
    int edgeCnt;

    expect_t     sbQueue[$];
    logic [1:0]  stimWe   [RUN_LEN];
    logic [63:0] stimAdr  [RUN_LEN];
    logic [63:0] stimData [RUN_LEN];

    store_result_monitor_if busIf ();

    store_result_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .store     (busIf.slave),
        .pass      (pass),
        .fail      (fail),
        .done      (done),
        .pass_id   (passId),
        .cycle_cnt (cycleCnt),
        .store_cnt (storeCnt)
`ifdef STORE_LOG_EN
        ,
        .last_adr  (lastAdr),
        .last_data (lastData),
        .last_we   (lastWe)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release, used to check verdict latency.
    always @(posedge clk or posedge reset) begin
        if (reset) edgeCnt <= 0;
        else       edgeCnt <= edgeCnt + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Which signature a store carries, in priority order; 0 means none.
    function automatic int sigId(input logic [1:0] we, input logic [63:0] a, input logic [63:0] d);
        if (we == 2'b00) return 0;
        if (a == 64'd84  && d == 64'd7) return 1;
        if (a == 64'd128 && d == 64'd7) return 2;
        if (a == 64'd80  && d == 64'd1) return 3;
        return 0;
    endfunction

    // Reference: the verdict is decided by the first signature store in the
    // script; if it falls inside the first TIMEOUT cycles it is a pass at that
    // cycle, otherwise the watchdog wins at cycle TIMEOUT-1. Store count and
    // log cover the script up to and including the deciding cycle.
    function automatic expect_t referenceModel();
        expect_t e;
        int firstMatch;
        int horizon;
        int stores;
        firstMatch = -1;
        stores     = 0;
        e.expAdr   = 64'd0;
        e.expData  = 64'd0;
        e.expWe    = 2'd0;
        for (int i = 0; i < RUN_LEN; i++) begin
            if (firstMatch < 0 && sigId(stimWe[i], stimAdr[i], stimData[i]) != 0) firstMatch = i;
        end
        if (firstMatch >= 0 && firstMatch < TIMEOUT) begin
            e.expPass  = 1'b1;
            e.expFail  = 1'b0;
            e.expId    = 2'(sigId(stimWe[firstMatch], stimAdr[firstMatch], stimData[firstMatch]));
            horizon    = firstMatch;
        end else begin
            e.expPass  = 1'b0;
            e.expFail  = 1'b1;
            e.expId    = 2'd0;
            horizon    = TIMEOUT - 1;
        end
        e.expCycle = horizon;
        e.expEdge  = horizon + 1;
        for (int i = 0; i <= horizon; i++) begin
            if (stimWe[i] != 2'b00) begin
                stores++;
                e.expAdr  = stimAdr[i];
                e.expData = stimData[i];
                e.expWe   = stimWe[i];
            end
        end
        e.expStores = (stores > 255) ? 255 : stores;
        return e;
    endfunction

    // Monitor: compares the queued expectation whenever done rises.
    initial begin
        logic    prevDone;
        expect_t e;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevDone = 1'b0;
            end else begin
                if (done && !prevDone) begin
                    if (sbQueue.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpectedDone: got done=1, expected no verdict");
                    end else begin
                        e = sbQueue.pop_front();
                        checkOutput("mon pass",      64'(pass),     64'(e.expPass));
                        checkOutput("mon fail",      64'(fail),     64'(e.expFail));
                        checkOutput("mon pass_id",   64'(passId),   64'(e.expId));
                        checkOutput("mon cycle_cnt", 64'(cycleCnt), 64'(e.expCycle));
                        checkOutput("mon store_cnt", 64'(storeCnt), 64'(e.expStores));
                        checkOutput("mon latency",   64'(edgeCnt),  64'(e.expEdge));
`ifdef STORE_LOG_EN
                        checkOutput("mon last_adr",  lastAdr,       e.expAdr);
                        checkOutput("mon last_data", lastData,      e.expData);
                        checkOutput("mon last_we",   64'(lastWe),   64'(e.expWe));
`endif
                    end
                end
                prevDone = done;
            end
        end
    end

    task automatic clearStim();
        for (int i = 0; i < RUN_LEN; i++) begin
            stimWe[i]   = 2'b00;
            stimAdr[i]  = 64'd0;
            stimData[i] = 64'd0;
        end
    endtask

    task automatic putStore(input int i, input logic [1:0] we, input logic [63:0] a, input logic [63:0] d);
        stimWe[i]   = we;
        stimAdr[i]  = a;
        stimData[i] = d;
    endtask

    task automatic restartRun();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Runs one script: reset must be asserted on entry; releases reset,
    // drives one script entry per cycle and checks the held verdict after.
    task automatic applyStimulus(input string tag);
        expect_t e;
        e = referenceModel();
        sbQueue.push_back(e);
        checkOutput({tag, " reset done"},      64'(done),     64'd0);
        checkOutput({tag, " reset cycle_cnt"}, 64'(cycleCnt), 64'd0);
        checkOutput({tag, " reset store_cnt"}, 64'(storeCnt), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < RUN_LEN; i++) begin
            busIf.memwrite  = stimWe[i];
            busIf.dataadr   = stimAdr[i];
            busIf.writedata = stimData[i];
            @(posedge clk);
            @(negedge clk);
        end
        busIf.memwrite  = 2'b00;
        busIf.dataadr   = 64'd0;
        busIf.writedata = 64'd0;
        if (sbQueue.size() != 0) begin
            checks++;
            $display("[TB] FAIL %s doneTimeout: got done=%0d, expected verdict within %0d cycles", tag, done, TIMEOUT);
            void'(sbQueue.pop_front());
        end
        checkOutput({tag, " held pass"},      64'(pass),     64'(e.expPass));
        checkOutput({tag, " held fail"},      64'(fail),     64'(e.expFail));
        checkOutput({tag, " held pass_id"},   64'(passId),   64'(e.expId));
        checkOutput({tag, " held cycle_cnt"}, 64'(cycleCnt), 64'(e.expCycle));
        checkOutput({tag, " held store_cnt"}, 64'(storeCnt), 64'(e.expStores));
    endtask

    initial begin
        logic [1:0] we;
        logic [63:0] a;
        logic [63:0] d;
        int mode;
        int rate;

        reset           = 1'b1;
        busIf.memwrite  = 2'b00;
        busIf.dataadr   = 64'd0;
        busIf.writedata = 64'd0;

        // standard2 signature at cycle 5, reset released at 22 ns
        clearStim();
        putStore(5, 2'b01, 64'd84, 64'd7);
        #22;
        applyStimulus("std2");

        // asynchronous reset between edges clears the verdict at once
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async pass",      64'(pass),     64'd0);
        checkOutput("async fail",      64'(fail),     64'd0);
        checkOutput("async done",      64'(done),     64'd0);
        checkOutput("async pass_id",   64'(passId),   64'd0);
        checkOutput("async cycle_cnt", 64'(cycleCnt), 64'd0);
        checkOutput("async store_cnt", 64'(storeCnt), 64'd0);

        // power2 signature
        clearStim();
        putStore(3, 2'b11, 64'd128, 64'd7);
        restartRun();
        applyStimulus("pwr2");

        // loadstore, then a later standard2 store that must be ignored
        clearStim();
        putStore(7, 2'b10, 64'd80, 64'd1);
        putStore(12, 2'b01, 64'd84, 64'd7);
        restartRun();
        applyStimulus("ls");

        // 300 near-miss stores then silence: timeout with saturated count
        clearStim();
        for (int i = 0; i < 300; i++) putStore(i, 2'($urandom_range(1, 3)), 64'd84, 64'd6);
        restartRun();
        applyStimulus("timeout");

        // signature on the very last watchdog cycle wins over the timeout
        clearStim();
        putStore(TIMEOUT - 1, 2'b01, 64'd80, 64'd1);
        restartRun();
        applyStimulus("lastCycle");

`ifdef STORE_LOG_EN
        // log keeps the final store before the timeout
        clearStim();
        putStore(0, 2'b10, 64'd16, 64'd3);
        putStore(1, 2'b01, 64'd24, 64'd9);
        restartRun();
        applyStimulus("log");
        checkOutput("log last_adr",  lastAdr,      64'd24);
        checkOutput("log last_data", lastData,     64'd9);
        checkOutput("log last_we",   64'(lastWe),  64'd1);
`endif

        // randomized scripts mixing signatures, near misses and noise
        for (int r = 0; r < 10; r++) begin
            clearStim();
            mode = int'($urandom_range(0, 1));
            rate = int'($urandom_range(2, 12));
            for (int i = 0; i < RUN_LEN; i++) begin
                if ($urandom_range(0, rate - 1) == 0) begin
                    we = 2'($urandom_range(1, 3));
                    case ($urandom_range(0, 3))
                        0:       a = 64'd84;
                        1:       a = 64'd128;
                        2:       a = 64'd80;
                        default: a = {32'($urandom), 32'($urandom)};
                    endcase
                    if (mode == 0) begin
                        case ($urandom_range(0, 3))
                            0:       d = 64'd7;
                            1:       d = 64'd1;
                            2:       d = 64'd6;
                            default: d = 64'($urandom);
                        endcase
                    end else begin
                        case ($urandom_range(0, 2))
                            0:       d = 64'd6;
                            1:       d = 64'd2;
                            default: d = 64'h100 + 64'($urandom_range(0, 1000));
                        endcase
                    end
                    putStore(i, we, a, d);
                end
            end
            restartRun();
            applyStimulus($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
